// File: rtl/cmp_flag_unit_pkg.sv
// rtl/cmp_flag_unit_pkg.sv - shared types and sizing for the compare/flag unit
// CMP_SIGNED_FLAGS_EN adds sf/of to the flags struct.
package cmp_flag_unit_pkg;

  localparam int CMP_WIDTH  = 16;
  localparam int CMP_SLICE  = 4;
  localparam int NUM_SLICES = CMP_WIDTH / CMP_SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic zf;
    logic cf;
`ifdef CMP_SIGNED_FLAGS_EN
    logic sf;
    logic of;
`endif
  } cmp_flags_t;

endpackage

// File: rtl/cmp_slice_sub.sv
// rtl/cmp_slice_sub.sv - combinational SLICE-bit subtract with borrow
module cmp_slice_sub #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             borrow_in,
  output logic [SLICE-1:0] diff,
  output logic             borrow_out,
  output logic             is_zero
);

  logic [SLICE:0] res;

  // One extra bit so the borrow falls out as the top bit of the difference.
  always_comb begin
    res        = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, borrow_in};
    diff       = res[SLICE-1:0];
    borrow_out = res[SLICE];
    is_zero    = (res[SLICE-1:0] == '0);
  end

endmodule

// File: rtl/cmp_flag_unit.sv
// rtl/cmp_flag_unit.sv - multi-cycle A-B compare producing registered zf/cf flags
// Define CMP_SIGNED_FLAGS_EN to add registered sf/of outputs.
module cmp_flag_unit
  import cmp_flag_unit_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int SLICE = CMP_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmp_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flags_clr,
  output logic             busy,
  output logic             cmp_done,
  output logic             zf,
  output logic             cf,
`ifdef CMP_SIGNED_FLAGS_EN
  output logic             sf,
  output logic             of,
`endif
  output logic             flags_valid
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  cmp_state_e       state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [IDX_W-1:0] idx;
  logic             borrow;
  logic             zacc;
  logic             last_slice;
  logic             load_flags;
  cmp_flags_t       flags_q, flags_new;
  logic             valid_q;
  logic             done_q;

  logic [SLICE-1:0] slice_diff;
  logic             slice_borrow;
  logic             slice_zero;

`ifdef CMP_SIGNED_FLAGS_EN
  logic             a_msb;
`endif

  cmp_slice_sub #(.SLICE(SLICE)) u_slice (
    .a          (a_sh[int'(idx)*SLICE +: SLICE]),
    .b          (b_sh[int'(idx)*SLICE +: SLICE]),
    .borrow_in  (borrow),
    .diff       (slice_diff),
    .borrow_out (slice_borrow),
    .is_zero    (slice_zero)
  );

  assign last_slice = (idx == IDX_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_flags = 1'b0;
    case (state)
      IDLE: if (cmp_start) state_nxt = CALC;
      CALC: if (last_slice) state_nxt = DONE;
      DONE: begin
        load_flags = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // By DONE, a_sh holds the full difference: each A slice is overwritten once consumed.
  always_comb begin
    flags_new    = '0;
    flags_new.zf = zacc;
    flags_new.cf = borrow;
`ifdef CMP_SIGNED_FLAGS_EN
    flags_new.sf = a_sh[WIDTH-1];
    flags_new.of = (a_msb ^ b_sh[WIDTH-1]) & (a_sh[WIDTH-1] ^ a_msb);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      zacc   <= 1'b1;
`ifdef CMP_SIGNED_FLAGS_EN
      a_msb  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cmp_start) begin
          a_sh   <= op_a;
          b_sh   <= op_b;
          idx    <= '0;
          borrow <= 1'b0;
          zacc   <= 1'b1;
`ifdef CMP_SIGNED_FLAGS_EN
          a_msb  <= op_a[WIDTH-1];
`endif
        end
        CALC: begin
          a_sh[int'(idx)*SLICE +: SLICE] <= slice_diff;
          borrow <= slice_borrow;
          zacc   <= zacc & slice_zero;
          idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Clear has priority over a same-cycle load; cmp_done still pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= load_flags;
      if (flags_clr) begin
        flags_q <= '0;
        valid_q <= 1'b0;
      end else if (load_flags) begin
        flags_q <= flags_new;
        valid_q <= 1'b1;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign cmp_done    = done_q;
  assign zf          = flags_q.zf;
  assign cf          = flags_q.cf;
  assign flags_valid = valid_q;
`ifdef CMP_SIGNED_FLAGS_EN
  assign sf          = flags_q.sf;
  assign of          = flags_q.of;
`endif

endmodule

// File: tb/tb_cmp_flag_unit.sv
// tb/tb_cmp_flag_unit.sv - randomized self-checking bench for cmp_flag_unit
// Honours CMP_SIGNED_FLAGS_EN for the sf/of outputs.
module tb_cmp_flag_unit;
  import cmp_flag_unit_pkg::*;

  localparam int W = CMP_WIDTH;
  localparam int N = NUM_SLICES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmp_start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flags_clr = 1'b0;
  logic         busy, cmp_done, zf, cf, flags_valid;
  logic         sf_o, of_o;

  int checks = 0;
  int passes = 0;

  cmp_flag_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmp_start   (cmp_start),
    .op_a        (op_a),
    .op_b        (op_b),
    .flags_clr   (flags_clr),
    .busy        (busy),
    .cmp_done    (cmp_done),
    .zf          (zf),
    .cf          (cf),
`ifdef CMP_SIGNED_FLAGS_EN
    .sf          (sf_o),
    .of          (of_o),
`endif
    .flags_valid (flags_valid)
  );

`ifndef CMP_SIGNED_FLAGS_EN
  assign sf_o = 1'b0;
  assign of_o = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference: a compare accepted at an edge loads flags N+1 edges later.
  int           m_cnt = 0;
  logic [W-1:0] m_a, m_b;
  logic         m_done = 0, m_zf = 0, m_cf = 0, m_sf = 0, m_of = 0, m_fv = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_done = 0; m_zf = 0; m_cf = 0; m_sf = 0; m_of = 0; m_fv = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          logic [W-1:0] d;
          int r;
          m_done = 1;
          d = m_a - m_b;
          r = int'($signed(m_a)) - int'($signed(m_b));
          m_zf = (m_a == m_b);
          m_cf = (m_a < m_b);
`ifdef CMP_SIGNED_FLAGS_EN
          m_sf = d[W-1];
          m_of = (r > 32767) || (r < -32768);
`endif
          m_fv = 1;
        end
      end else if (cmp_start) begin
        m_cnt = N + 1;
        m_a = op_a;
        m_b = op_b;
      end
      if (flags_clr) begin
        m_zf = 0; m_cf = 0; m_sf = 0; m_of = 0; m_fv = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0] act, exp;
    act = {busy, cmp_done, zf, cf, flags_valid, sf_o, of_o};
    exp = {(m_cnt > 0), m_done, m_zf, m_cf, m_fv, m_sf, m_of};
    checks++;
    if (act === exp) passes++;
    else $display("FAIL cycle_cmp t=%0t act(busy,done,zf,cf,fv,sf,of)=%b exp=%b", $time, act, exp);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s act=%0h exp=%0h", name, act, exp);
  endtask

  task automatic start_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); #1;
    cmp_start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    cmp_start = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cmp_done && lat < 40);
    if (!cmp_done) check("wait_done_timeout", 0, 1);
  endtask

  int lat, ndone;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {busy, cmp_done, zf, cf, flags_valid}, 5'b00000);
    rst_n = 1'b1;

    start_cmp(16'h1234, 16'h1234);
    wait_done(lat);
    check("latency", lat, 5);
    check("eq_flags", {zf, cf, flags_valid}, 3'b101);

    start_cmp(16'h0001, 16'h0002);
    wait_done(lat);
    check("lt_flags", {zf, cf}, 2'b01);

    start_cmp(16'h8000, 16'h7FFF);
    wait_done(lat);
    check("ripple_flags", {zf, cf}, 2'b00);

    // Second start during CALC must be dropped.
    start_cmp(16'h0005, 16'h0009);
    @(negedge clk); #1;
    cmp_start = 1'b1; op_a = 16'h0009; op_b = 16'h0009;
    @(posedge clk); #1;
    cmp_start = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (cmp_done) ndone++;
    end
    check("ignored_start_done_count", ndone, 1);
    check("ignored_start_flags", {zf, cf}, 2'b01);

    // Async reset in the middle of CALC.
    start_cmp(16'h0003, 16'h0007);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_calc_reset", {busy, cmp_done, zf, cf, flags_valid}, 5'b00000);
    @(negedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (cmp_done) ndone++;
    end
    check("no_done_after_reset", ndone, 0);
    start_cmp(16'h00FF, 16'h00FF);
    wait_done(lat);
    check("post_reset_eq", {zf, cf, flags_valid}, 3'b101);

    // Clear in the DONE cycle wins over the load.
    start_cmp(16'h0010, 16'h0020);
    repeat (N) @(posedge clk);
    #1;
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    check("clr_at_done_pulse", cmp_done, 1);
    check("clr_at_done_flags", {zf, cf, flags_valid}, 3'b000);

`ifdef CMP_SIGNED_FLAGS_EN
    start_cmp(16'h8000, 16'h0001);
    wait_done(lat);
    check("signed_flags", {sf_o, of_o, cf, zf}, 4'b0100);
`endif

    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #1;
      cmp_start = ($urandom_range(0, 3) == 0);
      op_a = W'($urandom);
      op_b = ($urandom_range(0, 3) == 0) ? op_a : W'($urandom);
      if ($urandom_range(0, 7) == 0) op_b = op_a + W'($urandom_range(0, 2)) - W'(1);
      flags_clr = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk); #1;
    cmp_start = 1'b0;
    flags_clr = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
